cpu64_m_div: RTL

Iterative radix-2 integer divider for the RV64M divide group: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW and REMUW. It sits in the execute stage beside cpu64_I_alu. The ALU finishes in a single cycle; this unit takes a variable, multi-cycle latency. Operands are accepted with a valid/ready handshake. The result is held on the output until the writeback side accepts it.

---
 rtl/cpu64_m_div.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu64_m_div.sv
// rtl/cpu64_m_div.sv - iterative radix-2 restoring divider for the RV64M divide group
// Accepts one operation at a time; result is held until the consumer takes it.
module cpu64_m_div #(
    parameter int XLEN_P = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [XLEN_P-1:0] a_i,
    input  logic [XLEN_P-1:0] b_i,
    input  logic [2:0]        op_i,
    input  logic              kill_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN_P-1:0] result_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPECIAL,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] dvd_q, dvd_d;
    logic [63:0] dvs_q, dvs_d;
    logic [63:0] quo_q, quo_d;
    logic [63:0] rem_q, rem_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        word_q, word_d;
    logic        rem_sel_q, rem_sel_d;
    logic        div_zero_q, div_zero_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;

    logic        op_word, op_rem, op_uns;
    logic [63:0] a_ext, b_ext, a_mag, b_mag, a_sx;
    logic        a_neg, b_neg, b_zero, ovf;
    logic [64:0] rem_shift, trial;
    logic [63:0] quo_fix, rem_fix, fix_sel, fix_res, spec_res;

    assign op_word = op_i[2];
    assign op_rem  = op_i[1];
    assign op_uns  = op_i[0];

    // Operands brought to a common 64-bit form so one datapath serves both widths.
    always_comb begin
        a_ext = a_i;
        b_ext = b_i;
        if (op_word) begin
            a_ext = op_uns ? {32'b0, a_i[31:0]} : {{32{a_i[31]}}, a_i[31:0]};
            b_ext = op_uns ? {32'b0, b_i[31:0]} : {{32{b_i[31]}}, b_i[31:0]};
        end
    end

    assign a_neg  = !op_uns && a_ext[63];
    assign b_neg  = !op_uns && b_ext[63];
    assign a_mag  = a_neg ? -a_ext : a_ext;
    assign b_mag  = b_neg ? -b_ext : b_ext;
    assign b_zero = (b_ext == 64'd0);
    assign a_sx   = op_word ? {{32{a_i[31]}}, a_i[31:0]} : a_i;
    assign ovf    = !op_uns && (op_word ?
                    (a_i[31:0] == 32'h8000_0000 && b_i[31:0] == 32'hFFFF_FFFF) :
                    (a_i == 64'h8000_0000_0000_0000 && b_i == 64'hFFFF_FFFF_FFFF_FFFF));

    // Restoring step: borrow out of bit 64 means the trial subtraction failed.
    assign rem_shift = {rem_q, quo_q[63]};
    assign trial     = rem_shift - {1'b0, dvs_q};

    assign quo_fix = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix = neg_rem_q ? -rem_q : rem_q;
    assign fix_sel = rem_sel_q ? rem_fix : quo_fix;
    assign fix_res = word_q ? {{32{fix_sel[31]}}, fix_sel[31:0]} : fix_sel;

    always_comb begin
        spec_res = 64'd0;
        if (div_zero_q) begin
            spec_res = rem_sel_q ? dvd_q : 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            spec_res = rem_sel_q ? 64'd0 : dvd_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        rem_sel_d  = rem_sel_q;
        div_zero_d = div_zero_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    state_d    = (b_zero || ovf) ? S_SPECIAL : S_CALC;
                    dvd_d      = a_sx;
                    dvs_d      = b_mag;
                    quo_d      = op_word ? {a_mag[31:0], 32'b0} : a_mag;
                    rem_d      = 64'd0;
                    cnt_d      = op_word ? 7'd32 : 7'd64;
                    word_d     = op_word;
                    rem_sel_d  = op_rem;
                    div_zero_d = b_zero;
                    neg_quo_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                end
            end
            S_SPECIAL: begin
                result_d = spec_res;
                state_d  = S_DONE;
            end
            S_CALC: begin
                if (!trial[64]) begin
                    rem_d = trial[63:0];
                    quo_d = {quo_q[62:0], 1'b1};
                end else begin
                    rem_d = rem_shift[63:0];
                    quo_d = {quo_q[62:0], 1'b0};
                end
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A flush beats everything, including an accept or a consume in the same cycle.
        if (kill_i) begin
            state_d = S_IDLE;
        end

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            dvd_q       <= 64'd0;
            dvs_q       <= 64'd0;
            quo_q       <= 64'd0;
            rem_q       <= 64'd0;
            cnt_q       <= 7'd0;
            word_q      <= 1'b0;
            rem_sel_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            result_q    <= 64'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            rem_sel_q   <= rem_sel_d;
            div_zero_q  <= div_zero_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign result_o    = result_q;

endmodule
